fnd_display_scheduler: RTL and testbench

//  Shares the single 4-digit FND between the vending-machine sources: coin balance, brew animation,

---
 rtl/fnd_sched_pkg.sv | 21 ++
 rtl/ms_hold_timer.sv | 40 ++++
 rtl/fnd_display_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_fnd_display_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_sched_pkg.sv
// Shared types and constants for the FND display scheduler.
// The state enum and display-mode / message codes are used by fnd_display_scheduler.
package fnd_sched_pkg;

    localparam int DATA_W = 14;

    typedef enum logic [1:0] {
        SHOW_BAL  = 2'd0,
        SHOW_BREW = 2'd1,
        SHOW_RET  = 2'd2,
        SHOW_ERR  = 2'd3
    } sched_state_e;

    localparam logic [1:0] DISP_MODE_NUM  = 2'b00;
    localparam logic [1:0] DISP_MODE_ANIM = 2'b01;
    localparam logic [1:0] DISP_MODE_MSG  = 2'b10;

    localparam logic [1:0] MSG_RET = 2'b00;
    localparam logic [1:0] MSG_ERR = 2'b01;

endpackage

// File: rtl/ms_hold_timer.sv
// Millisecond hold timer: loadable down-counter that decrements only on tick
// and never wraps below zero. expire flags the tick on which the count runs out,
// so the owner can leave its state on that same cycle. A load in the same cycle
// as a tick wins and suppresses both the decrement and expire.
module ms_hold_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: reload has priority, otherwise tick-gated decrement held at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = tick && !load && (count_q <= WIDTH'(1));

endmodule

// File: rtl/fnd_display_scheduler.sv
// FND display scheduler: arbitrates the single 4-digit display between the
// coin balance, brew animation, coin-return overlay and error overlay.
// Overlays hold for HOLD_MS ticks of the 1 kHz tick.
// Optional feature: define FND_SCHED_BLINK_EN to blink the display during the
// error overlay with a BLINK_MS-tick half period; otherwise disp_blank is 0.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  SHOW_BAL  | live coin balance, NUM mode
//  SHOW_BREW | brew animation, balance on data, ANIM mode
//  SHOW_RET  | returned amount overlay, NUM mode, busy
//  SHOW_ERR  | "Err" message overlay, MSG mode, busy
module fnd_display_scheduler
    import fnd_sched_pkg::*;
#(
    parameter int HOLD_MS  = 2000,
    parameter int BLINK_MS = 250
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [DATA_W-1:0] coin_val,
    input  logic              brew_active,
    input  logic              ret_pulse,
    input  logic [DATA_W-1:0] ret_amt,
    input  logic              err_pulse,
    output logic [DATA_W-1:0] disp_data,
    output logic [1:0]        disp_mode,
    output logic [1:0]        msg_code,
    output logic              disp_blank,
    output logic              busy
);

    localparam int HOLD_W = $clog2(HOLD_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_MS);

    if ((HOLD_MS < 1) || (HOLD_MS > 65535)) begin : g_bad_hold
        $error("fnd_display_scheduler: HOLD_MS must be in 1..65535");
    end
    if (BLINK_MS < 1) begin : g_bad_blink
        $error("fnd_display_scheduler: BLINK_MS must be at least 1");
    end

    sched_state_e      state_q, state_d;
    logic [DATA_W-1:0] ret_amt_q, ret_amt_d;
    logic              load_hold;
    logic              hold_expire;

    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [1:0]        disp_mode_q, disp_mode_d;
    logic [1:0]        msg_code_q, msg_code_d;
    logic              disp_blank_q, disp_blank_d;
    logic              busy_q, busy_d;

    ms_hold_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load_hold),
        .load_val (HOLD_LOAD),
        .expire   (hold_expire)
    );

    // State and latched return amount; reset drops any overlay at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SHOW_BAL;
            ret_amt_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_amt_q <= ret_amt_d;
        end
    end

    // Next state: error beats return beats brew; background views re-evaluated at overlay exit.
    always_comb begin
        state_d   = state_q;
        ret_amt_d = ret_amt_q;
        load_hold = 1'b0;
        if (err_pulse) begin
            state_d   = SHOW_ERR;
            load_hold = 1'b1;
        end else if (ret_pulse && (state_q != SHOW_ERR)) begin
            state_d   = SHOW_RET;
            ret_amt_d = ret_amt;
            load_hold = 1'b1;
        end else begin
            unique case (state_q)
                SHOW_BAL:  if (brew_active)  state_d = SHOW_BREW;
                SHOW_BREW: if (!brew_active) state_d = SHOW_BAL;
                SHOW_RET,
                SHOW_ERR:  if (hold_expire)  state_d = brew_active ? SHOW_BREW : SHOW_BAL;
                default:   state_d = SHOW_BAL;
            endcase
        end
    end

`ifdef FND_SCHED_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_MS + 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_MS);

    logic blink_q, blink_d;
    logic blink_load;
    logic blink_expire;

    ms_hold_timer #(.WIDTH(BLINK_W)) u_blink_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (blink_load),
        .load_val (BLINK_LOAD),
        .expire   (blink_expire)
    );

    // Blink phase: restarts dark-off on every error pulse, toggles each half period, cleared outside SHOW_ERR.
    always_comb begin
        blink_load = 1'b0;
        blink_d    = blink_q;
        if (err_pulse) begin
            blink_load = 1'b1;
            blink_d    = 1'b0;
        end else if (state_q == SHOW_ERR) begin
            if (blink_expire) begin
                blink_load = 1'b1;
                blink_d    = ~blink_q;
            end
        end else begin
            blink_d = 1'b0;
        end
    end

    // Blink phase register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    // Output decode from the current state; registered below for a clean 1-cycle latency.
    always_comb begin
        disp_data_d  = coin_val;
        disp_mode_d  = DISP_MODE_NUM;
        msg_code_d   = MSG_RET;
        disp_blank_d = 1'b0;
        busy_d       = 1'b0;
        unique case (state_q)
            SHOW_BAL: begin
                disp_data_d = coin_val;
                disp_mode_d = DISP_MODE_NUM;
            end
            SHOW_BREW: begin
                disp_data_d = coin_val;
                disp_mode_d = DISP_MODE_ANIM;
            end
            SHOW_RET: begin
                disp_data_d = ret_amt_q;
                disp_mode_d = DISP_MODE_NUM;
                busy_d      = 1'b1;
            end
            SHOW_ERR: begin
                disp_data_d = '0;
                disp_mode_d = DISP_MODE_MSG;
                msg_code_d  = MSG_ERR;
                busy_d      = 1'b1;
`ifdef FND_SCHED_BLINK_EN
                disp_blank_d = blink_q;
`endif
            end
            default: begin
                disp_data_d = coin_val;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            disp_data_q  <= '0;
            disp_mode_q  <= DISP_MODE_NUM;
            msg_code_q   <= MSG_RET;
            disp_blank_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            disp_data_q  <= disp_data_d;
            disp_mode_q  <= disp_mode_d;
            msg_code_q   <= msg_code_d;
            disp_blank_q <= disp_blank_d;
            busy_q       <= busy_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_mode  = disp_mode_q;
    assign msg_code   = msg_code_q;
    assign disp_blank = disp_blank_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Scoreboard bench for fnd_display_scheduler (HOLD_MS=5, BLINK_MS=2, tick every 10 clk).
// Stimulus pushes hand-computed expected outputs; the negedge monitor pops and compares.
module tb_fnd_display_scheduler;

    localparam logic [1:0] M_NUM  = 2'b00;
    localparam logic [1:0] M_ANIM = 2'b01;
    localparam logic [1:0] M_MSG  = 2'b10;
    localparam logic [1:0] C_RET  = 2'b00;
    localparam logic [1:0] C_ERR  = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [13:0] coin_val;
    logic        brew_active;
    logic        ret_pulse;
    logic [13:0] ret_amt;
    logic        err_pulse;
    logic [13:0] disp_data;
    logic [1:0]  disp_mode;
    logic [1:0]  msg_code;
    logic        disp_blank;
    logic        busy;

    typedef struct {
        string       nm;
        logic [13:0] d;
        logic [1:0]  m;
        logic [1:0]  mc;
        logic        bl;
        logic        bz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic blink_exp [0:4];

    fnd_display_scheduler #(.HOLD_MS(5), .BLINK_MS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .coin_val    (coin_val),
        .brew_active (brew_active),
        .ret_pulse   (ret_pulse),
        .ret_amt     (ret_amt),
        .err_pulse   (err_pulse),
        .disp_data   (disp_data),
        .disp_mode   (disp_mode),
        .msg_code    (msg_code),
        .disp_blank  (disp_blank),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // 1 ms tick stand-in: one-cycle pulse every 10 clocks, updated 1 ns after the edge.
    initial begin
        int cyc;
        cyc  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick = ((cyc % 10) == 0);
        end
    end

    // Monitor: compare the oldest expectation against the outputs mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp_data !== e.d || disp_mode !== e.m || msg_code !== e.mc ||
                disp_blank !== e.bl || busy !== e.bz) begin
                errors++;
                $display("FAIL %s: got data=%0d mode=%b msg=%b blank=%b busy=%b, expected data=%0d mode=%b msg=%b blank=%b busy=%b",
                         e.nm, disp_data, disp_mode, msg_code, disp_blank, busy,
                         e.d, e.m, e.mc, e.bl, e.bz);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input string nm, input logic [13:0] d, input logic [1:0] m,
                        input logic [1:0] mc, input logic bl, input logic bz);
        exp_t e;
        e.nm = nm; e.d = d; e.m = m; e.mc = mc; e.bl = bl; e.bz = bz;
        exp_q.push_back(e);
    endtask

    // Advance until the cycle whose edge samples tick=1, then let that edge pass.
    task automatic after_tick();
        int g;
        g = 0;
        while (tick !== 1'b1 && g < 30) begin
            step(1);
            g++;
        end
        if (tick !== 1'b1) begin
            $display("FAIL tick_wait: tick=%b after %0d cycles, required 1", tick, g);
            $fatal(1);
        end
        step(1);
    endtask

    // Check n further overlay ticks; k0 is the tick index since (re)entry for the blink phase.
    task automatic hold_ticks(input int n, input string nm, input logic [13:0] d,
                              input logic [1:0] m, input logic [1:0] mc,
                              input bit use_blink, input int k0);
        for (int k = 1; k <= n; k++) begin
            after_tick();
            step(1);
            push(nm, d, m, mc, use_blink ? blink_exp[k0 + k] : 1'b0, 1'b1);
        end
    endtask

    initial begin
`ifdef FND_SCHED_BLINK_EN
        blink_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        blink_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b0; coin_val = 14'd300; brew_active = 1'b0;
        ret_pulse = 1'b0; ret_amt = 14'd0; err_pulse = 1'b0;

        // Reset values, then live balance.
        step(3);
        push("reset", 14'd0, M_NUM, C_RET, 1'b0, 1'b0);
        reset = 1'b1;
        step(2);
        push("bal_after_reset", 14'd300, M_NUM, C_RET, 1'b0, 1'b0);
        coin_val = 14'd1234;
        step(2);
        push("bal_live", 14'd1234, M_NUM, C_RET, 1'b0, 1'b0);

        // Coin return overlay, balance drops to 0 underneath.
        after_tick();
        ret_pulse = 1'b1; ret_amt = 14'd700;
        step(1);
        ret_pulse = 1'b0; ret_amt = 14'd0; coin_val = 14'd0;
        step(1);
        push("ret_entry", 14'd700, M_NUM, C_RET, 1'b0, 1'b1);
        hold_ticks(4, "ret_hold", 14'd700, M_NUM, C_RET, 1'b0, 0);
        after_tick(); step(1);
        push("ret_exit", 14'd0, M_NUM, C_RET, 1'b0, 1'b0);

        // Brew, error overlay at tick 2, exit back to animation.
        coin_val = 14'd77; brew_active = 1'b1;
        step(2);
        push("brew", 14'd77, M_ANIM, C_RET, 1'b0, 1'b0);
        after_tick(); after_tick();
        err_pulse = 1'b1;
        step(1);
        err_pulse = 1'b0;
        step(1);
        push("err_entry", 14'd0, M_MSG, C_ERR, blink_exp[0], 1'b1);
        hold_ticks(4, "err_hold", 14'd0, M_MSG, C_ERR, 1'b1, 0);
        after_tick(); step(1);
        push("err_exit_brew", 14'd77, M_ANIM, C_RET, 1'b0, 1'b0);
        brew_active = 1'b0;
        step(2);
        push("brew_off", 14'd77, M_NUM, C_RET, 1'b0, 1'b0);

        // Error and return together: error wins, return amount never latched.
        coin_val = 14'd42;
        after_tick();
        err_pulse = 1'b1; ret_pulse = 1'b1; ret_amt = 14'd555;
        step(1);
        err_pulse = 1'b0; ret_pulse = 1'b0; ret_amt = 14'd0;
        step(1);
        push("err_ret_same", 14'd0, M_MSG, C_ERR, blink_exp[0], 1'b1);
        after_tick();
        ret_pulse = 1'b1; ret_amt = 14'd999;
        step(1);
        ret_pulse = 1'b0; ret_amt = 14'd0;
        push("ret_ignored_in_err", 14'd0, M_MSG, C_ERR, blink_exp[1], 1'b1);
        hold_ticks(3, "err_hold2", 14'd0, M_MSG, C_ERR, 1'b1, 1);
        after_tick(); step(1);
        push("err_exit_bal", 14'd42, M_NUM, C_RET, 1'b0, 1'b0);

        // Repeat error after 3 ticks restarts the hold: 8 ticks total.
        after_tick();
        err_pulse = 1'b1;
        step(1);
        err_pulse = 1'b0;
        step(1);
        push("err2_entry", 14'd0, M_MSG, C_ERR, blink_exp[0], 1'b1);
        hold_ticks(3, "err2_first", 14'd0, M_MSG, C_ERR, 1'b1, 0);
        err_pulse = 1'b1;
        step(1);
        err_pulse = 1'b0;
        step(1);
        push("err2_restart", 14'd0, M_MSG, C_ERR, blink_exp[0], 1'b1);
        hold_ticks(4, "err2_hold", 14'd0, M_MSG, C_ERR, 1'b1, 0);
        after_tick(); step(1);
        push("err2_exit", 14'd42, M_NUM, C_RET, 1'b0, 1'b0);

        // Reset in the middle of an overlay.
        after_tick();
        err_pulse = 1'b1;
        step(1);
        err_pulse = 1'b0;
        step(1);
        push("err3_entry", 14'd0, M_MSG, C_ERR, blink_exp[0], 1'b1);
        after_tick(); step(1);
        push("err3_t1", 14'd0, M_MSG, C_ERR, blink_exp[1], 1'b1);
        reset = 1'b0;
        step(1);
        push("rst_mid", 14'd0, M_NUM, C_RET, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);
        push("rst_release", 14'd42, M_NUM, C_RET, 1'b0, 1'b0);
        after_tick(); step(1);
        push("rst_stays_bal", 14'd42, M_NUM, C_RET, 1'b0, 1'b0);

        // Return re-latch restarts the hold; brew raised mid-overlay only acts at exit.
        after_tick();
        ret_pulse = 1'b1; ret_amt = 14'd100;
        step(1);
        ret_pulse = 1'b0; ret_amt = 14'd0;
        step(1);
        push("ret1_entry", 14'd100, M_NUM, C_RET, 1'b0, 1'b1);
        hold_ticks(2, "ret1_hold", 14'd100, M_NUM, C_RET, 1'b0, 0);
        ret_pulse = 1'b1; ret_amt = 14'd200; brew_active = 1'b1;
        step(1);
        ret_pulse = 1'b0; ret_amt = 14'd0;
        step(1);
        push("ret_relatch", 14'd200, M_NUM, C_RET, 1'b0, 1'b1);
        hold_ticks(4, "ret2_hold", 14'd200, M_NUM, C_RET, 1'b0, 0);
        after_tick(); step(1);
        push("ret_exit_brew", 14'd42, M_ANIM, C_RET, 1'b0, 1'b0);
        brew_active = 1'b0;

        step(3);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
            errors += exp_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
